// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronized line, mid-bit sampling, LSB-first data,
// one-cycle valid / frame-error pulses, and break-tolerant recovery.
`timescale 1ns/1ps

module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_busy,
   output logic [2:0]           o_dbg_state
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic                   rx_meta_q, rx_meta_d;
   logic                   rx_s_q, rx_s_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      rx_meta_d = i_rx;
      rx_s_d    = rx_meta_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) begin
               state_d = ST_START;
            end
         end

         // A start bit that has gone high again by mid-bit is a line glitch.
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  idx_d   = '0;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // o_data is only loaded from a complete frame with a good stop bit.
         ST_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = err_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, expected results
// queued at drive time and matched against o_valid / o_frame_err pulses.
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DB  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx  = 1'b1;
   logic [DB-1:0] o_data;
   logic          o_valid;
   logic          o_frame_err;
   logic          o_busy;
   logic [2:0]    o_dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // expected entry: {is_frame_err, o_data}
   logic [DB:0]   exp_q[$];
   logic [DB:0]   exp_item;
   logic [DB-1:0] prev_data;
   logic          prev_valid = 1'b0;
   logic          prev_err   = 1'b0;
   logic          rst_at_edge;
   logic          lat_armed  = 1'b0;
   int            lat_start  = 0;
   int            lat;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx        (rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy),
      .o_dbg_state (o_dbg_state)
   );

   // clock / reset bookkeeping
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (o_valid || o_frame_err) begin
         checks++;
         assert (!(o_valid && o_frame_err)) else begin
            errors++;
            $error("FAIL both_pulses got valid=%0b err=%0b want not both", o_valid, o_frame_err);
         end
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_pulse got valid=%0b err=%0b data=%h want none", o_valid, o_frame_err, o_data);
         end
         if (exp_q.size() > 0) begin
            exp_item = exp_q.pop_front();
            checks++;
            assert ({o_frame_err, o_data} === exp_item) else begin
               errors++;
               $error("FAIL frame_result got err=%0b data=%h want err=%0b data=%h",
                      o_frame_err, o_data, exp_item[DB], exp_item[DB-1:0]);
            end
         end
         if (o_valid && lat_armed) begin
            lat_armed = 1'b0;
            lat       = cyc - lat_start;
            checks++;
            assert (lat >= 155 && lat <= 157) else begin
               errors++;
               $error("FAIL latency got %0d want 155..157", lat);
            end
         end
      end
      if (prev_valid) begin
         checks++;
         assert (o_valid === 1'b0) else begin
            errors++;
            $error("FAIL valid_width got %0b want 0 on second cycle", o_valid);
         end
      end
      if (prev_err) begin
         checks++;
         assert (o_frame_err === 1'b0) else begin
            errors++;
            $error("FAIL err_width got %0b want 0 on second cycle", o_frame_err);
         end
      end
      if (!o_valid && rst_at_edge === 1'b0) begin
         checks++;
         assert (o_data === prev_data) else begin
            errors++;
            $error("FAIL data_hold got %h want %h", o_data, prev_data);
         end
      end
      prev_data  = o_data;
      prev_valid = o_valid;
      prev_err   = o_frame_err;
   end

   // driver tasks
   task automatic drive_frame(input logic [DB-1:0] d, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < DB; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL drain got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_bit(input string tag, input logic got, input logic want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0b want %0b", tag, got, want);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      assert (o_data === 8'h00 && o_valid === 1'b0 && o_frame_err === 1'b0 &&
              o_busy === 1'b0 && o_dbg_state === 3'd0) else begin
         errors++;
         $error("FAIL %s got data=%h v=%0b e=%0b busy=%0b st=%0d want all 0",
                tag, o_data, o_valid, o_frame_err, o_busy, o_dbg_state);
      end
   endtask

   // directed sequence
   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_state");
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_idle_outputs("idle_after_reset");

      // good frame with latency measurement
      lat_start = cyc;
      lat_armed = 1'b1;
      exp_q.push_back({1'b0, 8'hA5});
      drive_frame(8'hA5, 1'b1);
      rx = 1'b1;
      wait_drain(40);
      check_bit("latency_seen", lat_armed, 1'b0);
      repeat (20) @(negedge clk);

      // bad stop bit followed by a held-low break
      exp_q.push_back({1'b1, 8'hA5});
      drive_frame(8'h3C, 1'b0);
      repeat (64) @(negedge clk);
      check_bit("busy_in_break", o_busy, 1'b1);
      checks++;
      assert (o_dbg_state === 3'd4) else begin
         errors++;
         $error("FAIL break_state got %0d want 4", o_dbg_state);
      end
      rx = 1'b1;
      repeat (4) @(negedge clk);
      check_bit("busy_after_break", o_busy, 1'b0);
      wait_drain(1);
      repeat (20) @(negedge clk);

      // short low glitch must be rejected
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      check_bit("busy_in_glitch", o_busy, 1'b1);
      repeat (CPB / 2 - 2) @(negedge clk);
      check_bit("busy_after_glitch", o_busy, 1'b0);
      repeat (20) @(negedge clk);

      // back-to-back frames, no idle gap
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'hFF});
      drive_frame(8'h00, 1'b1);
      drive_frame(8'hFF, 1'b1);
      rx = 1'b1;
      wait_drain(40);
      repeat (20) @(negedge clk);

      // reset during data bit 4 aborts the frame
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = (8'hC3 >> i) & 1'b1;
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      check_idle_outputs("mid_frame_reset");
      repeat (40) @(negedge clk);
      check_idle_outputs("after_abort_idle");

      exp_q.push_back({1'b0, 8'h5A});
      drive_frame(8'h5A, 1'b1);
      rx = 1'b1;
      wait_drain(40);
      repeat (5) @(negedge clk);
      checks++;
      assert (o_data === 8'h5A) else begin
         errors++;
         $error("FAIL final_data got %h want 5a", o_data);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
